// File: rtl/dcache_responder_if.sv
// Datapath-side and memory-side signal bundle of the L1 data cache.
// The slave modport is the cache; the master modport is its environment.
interface dcache_responder_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        snoop_valid;
  logic [31:0] snoop_addr;

  modport master (
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt,
    output dwait, dload, snoop_valid, snoop_addr,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport slave (
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt,
    input  dwait, dload, snoop_valid, snoop_addr,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate L1 data cache with one word per line,
// LL/SC link register killed by remote-write snoops, and flush-on-halt.
module dcache_responder #(
  parameter int SETS = 16
) (
  input logic               CLK,
  input logic               nRST,
  dcache_responder_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(SETS - 1);

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, FLUSH_WB, DONE} state_t;

  state_t            state;
  logic [31:0]       data_arr [SETS];
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic              link_valid;
  logic [29:0]       link_addr;
  logic [IDX_W:0]    cnt;
  logic [29:0]       miss_addr;
  logic              dren_q;
  logic              dwen_q;
  logic [31:0]       daddr_q;
  logic [31:0]       dstore_q;
  logic              flushed_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  flush_idx;
  logic              req_hit;
  logic              link_match;

  logic              dhit_c;
  logic [31:0]       load_c;
  logic              hit_we;
  logic              ll_set;
  logic              link_clr;
  logic              miss;
  logic              link_valid_nxt;
  logic [29:0]       link_addr_nxt;
  logic              unused_low_bits;

  assign req_idx    = bus.dmemaddr[IDX_W+1:2];
  assign req_tag    = bus.dmemaddr[31:IDX_W+2];
  assign miss_idx   = miss_addr[IDX_W-1:0];
  assign miss_tag   = miss_addr[29:IDX_W];
  assign flush_idx  = cnt[IDX_W-1:0];
  assign req_hit    = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign link_match = link_valid && (link_addr == bus.dmemaddr[31:2]);
  assign unused_low_bits = ^{bus.dmemaddr[1:0], bus.snoop_addr[1:0]};

  // Request decode; only IDLE answers the datapath, and halt pre-empts any request.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    dhit_c   = 1'b0;
    load_c   = '0;
    hit_we   = 1'b0;
    ll_set   = 1'b0;
    link_clr = 1'b0;
    miss     = 1'b0;
    if (nRST && state == IDLE && !bus.halt) begin
      if (bus.dmemREN) begin
        if (req_hit) begin
          dhit_c = 1'b1;
          load_c = data_arr[req_idx];
          ll_set = bus.datomic;
        end else begin
          miss = 1'b1;
        end
      end else if (bus.dmemWEN) begin
        if (bus.datomic && !link_match) begin
          dhit_c = 1'b1;
        end else if (req_hit) begin
          dhit_c   = 1'b1;
          hit_we   = 1'b1;
          load_c   = {31'b0, bus.datomic};
          link_clr = link_match;
        end else begin
          miss = 1'b1;
        end
      end
    end
  end

  // A snoop compares against the post-update link, so it beats a same-cycle LL.
  always_comb begin
    link_valid_nxt = link_valid;
    link_addr_nxt  = link_addr;
    if (ll_set) begin
      link_valid_nxt = 1'b1;
      link_addr_nxt  = bus.dmemaddr[31:2];
    end else if (link_clr) begin
      link_valid_nxt = 1'b0;
    end
    if (bus.snoop_valid && bus.snoop_addr[31:2] == link_addr_nxt)
      link_valid_nxt = 1'b0;
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge CLK) begin
    if (hit_we) begin
      data_arr[req_idx] <= bus.dmemstore;
    end else if (state == FETCH && !bus.dwait) begin
      data_arr[miss_idx] <= bus.dload;
      tag_arr[miss_idx]  <= miss_tag;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      link_valid <= 1'b0;
      link_addr  <= '0;
      cnt        <= '0;
      miss_addr  <= '0;
      dren_q     <= 1'b0;
      dwen_q     <= 1'b0;
      daddr_q    <= '0;
      dstore_q   <= '0;
      flushed_q  <= 1'b0;
    end else begin
      link_valid <= link_valid_nxt;
      link_addr  <= link_addr_nxt;
      case (state)
        IDLE: begin
          if (bus.halt) begin
            state <= FLUSH;
            cnt   <= '0;
          end else begin
            if (hit_we) dirty[req_idx] <= 1'b1;
            if (miss) begin
              miss_addr <= bus.dmemaddr[31:2];
              if (valid[req_idx] && dirty[req_idx]) begin
                state    <= WB;
                dwen_q   <= 1'b1;
                daddr_q  <= {tag_arr[req_idx], req_idx, 2'b00};
                dstore_q <= data_arr[req_idx];
              end else begin
                state   <= FETCH;
                dren_q  <= 1'b1;
                daddr_q <= {bus.dmemaddr[31:2], 2'b00};
              end
            end
          end
        end
        WB: begin
          if (!bus.dwait) begin
            dirty[miss_idx] <= 1'b0;
            dwen_q          <= 1'b0;
            dstore_q        <= '0;
            dren_q          <= 1'b1;
            daddr_q         <= {miss_addr, 2'b00};
            state           <= FETCH;
          end
        end
        FETCH: begin
          // The fill completes regardless of whether the request is still present.
          if (!bus.dwait) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            dren_q          <= 1'b0;
            daddr_q         <= '0;
            state           <= IDLE;
          end
        end
        FLUSH: begin
          if (valid[flush_idx] && dirty[flush_idx]) begin
            state    <= FLUSH_WB;
            dwen_q   <= 1'b1;
            daddr_q  <= {tag_arr[flush_idx], flush_idx, 2'b00};
            dstore_q <= data_arr[flush_idx];
          end else if (cnt == LAST_IDX) begin
            state     <= DONE;
            flushed_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FLUSH_WB: begin
          // Returning to FLUSH with the same cnt re-examines a now-clean line and advances.
          if (!bus.dwait) begin
            dirty[flush_idx] <= 1'b0;
            dwen_q           <= 1'b0;
            daddr_q          <= '0;
            dstore_q         <= '0;
            state            <= FLUSH;
          end
        end
        DONE: begin
          flushed_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dhit     = dhit_c;
  assign bus.dmemload = load_c;
  assign bus.flushed  = flushed_q;
  assign bus.dREN     = dren_q;
  assign bus.dWEN     = dwen_q;
  assign bus.daddr    = daddr_q;
  assign bus.dstore   = dstore_q;
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a small memory model with configurable wait
// states answers the memory port while scenario tasks drive the datapath side.
module tb_dcache_responder;
  logic CLK;
  logic nRST;
  dcache_responder_if bus();

  dcache_responder #(.SETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_ev_t;

  mem_ev_t     ev_q[$];
  logic [31:0] mem [logic [31:0]];
  int          wait_cfg   = 0;
  int          wcnt       = 0;
  int          dren_cyc   = 0;
  int          both_cnt   = 0;
  int          checks     = 0;
  int          errors     = 0;

  // Memory side: decides dwait/dload on the falling edge so the cache sees them at the next rise.
  always @(negedge CLK) begin
    mem_ev_t ev;
    if (!nRST) begin
      wcnt      = 0;
      bus.dwait = 1'b0;
    end else if (bus.dREN || bus.dWEN) begin
      if (bus.dREN) dren_cyc++;
      if (bus.dREN && bus.dWEN) both_cnt++;
      if (wcnt < wait_cfg) begin
        bus.dwait = 1'b1;
        wcnt++;
      end else begin
        bus.dwait = 1'b0;
        wcnt      = 0;
        ev.wr     = bus.dWEN;
        ev.addr   = bus.daddr;
        if (bus.dWEN) begin
          mem[bus.daddr] = bus.dstore;
          ev.data        = bus.dstore;
        end else begin
          bus.dload = mem.exists(bus.daddr) ? mem[bus.daddr] : 32'h0;
          ev.data   = bus.dload;
        end
        ev_q.push_back(ev);
      end
    end else begin
      bus.dwait = 1'b0;
    end
  end

  task automatic idle();
    @(negedge CLK);
    bus.dmemREN     = 1'b0;
    bus.dmemWEN     = 1'b0;
    bus.datomic     = 1'b0;
    bus.snoop_valid = 1'b0;
  endtask

  // Presents one request and waits (bounded) for dhit; cyc counts cycles beyond the first.
  task automatic run_req(input logic ren, input logic wen, input logic atom,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic got, output int cyc, output logic [31:0] load);
    @(negedge CLK);
    bus.dmemREN   = ren;
    bus.dmemWEN   = wen;
    bus.datomic   = atom;
    bus.dmemaddr  = addr;
    bus.dmemstore = data;
    got  = 1'b0;
    cyc  = 0;
    load = 32'hX;
    #1;
    while (!got && cyc < 100) begin
      if (bus.dhit) begin
        got  = 1'b1;
        load = bus.dmemload;
      end else begin
        @(negedge CLK);
        #1;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #1;
    checks++;
    if ({bus.dhit, bus.flushed, bus.dREN, bus.dWEN} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000", {bus.dhit, bus.flushed, bus.dREN, bus.dWEN});
    end
    checks++;
    if ({bus.dmemload, bus.daddr, bus.dstore} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h exp 0", bus.dmemload, bus.daddr, bus.dstore);
    end
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic got; int cyc; logic [31:0] load;
    mem[32'h40] = 32'hDEADBEEF;
    wait_cfg = 2;
    dren_cyc = 0;
    ev_q.delete();
    run_req(1, 0, 0, 32'h40, 0, got, cyc, load);
    checks++;
    if (!got || cyc != 4) begin
      errors++;
      $display("FAIL cold_latency got %0d (hit %b) exp 4", cyc, got);
    end
    checks++;
    if (load !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cold_load got %h exp deadbeef", load);
    end
    checks++;
    if (dren_cyc != 3) begin
      errors++;
      $display("FAIL cold_dren_cycles got %0d exp 3", dren_cyc);
    end
    checks++;
    if (ev_q.size() != 1 || ev_q[0].wr !== 1'b0 || ev_q[0].addr !== 32'h40) begin
      errors++;
      $display("FAIL cold_fetch_addr got n=%0d addr %h exp 1 read at 00000040",
               ev_q.size(), ev_q.size() > 0 ? ev_q[0].addr : 32'h0);
    end
    wait_cfg = 0;
    idle();
  endtask

  task automatic test_dirty_evict();
    logic got; int cyc; logic [31:0] load;
    mem[32'h440] = 32'hCAFEF00D;
    ev_q.delete();
    run_req(0, 1, 0, 32'h40, 32'h1234, got, cyc, load);
    checks++;
    if (!got || cyc != 0 || load !== 32'h0) begin
      errors++;
      $display("FAIL sw_hit got cyc %0d load %h exp 0 0", cyc, load);
    end
    run_req(1, 0, 0, 32'h440, 0, got, cyc, load);
    checks++;
    if (!got || cyc != 3 || load !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL dirty_miss got cyc %0d load %h exp 3 cafef00d", cyc, load);
    end
    checks++;
    if (ev_q.size() != 2 || ev_q[0] !== {1'b1, 32'h40, 32'h1234} ||
        ev_q[1] !== {1'b0, 32'h440, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL wb_then_fetch got n=%0d exp WB 40=1234 then FETCH 440", ev_q.size());
    end
    idle();
  endtask

  task automatic test_ll_sc();
    logic got; int cyc; logic [31:0] load;
    mem[32'h80] = 32'h55;
    run_req(1, 0, 1, 32'h80, 0, got, cyc, load);
    checks++;
    if (!got || cyc != 2 || load !== 32'h55) begin
      errors++;
      $display("FAIL ll_miss got cyc %0d load %h exp 2 00000055", cyc, load);
    end
    run_req(0, 1, 1, 32'h80, 32'h7, got, cyc, load);
    checks++;
    if (!got || cyc != 0 || load !== 32'h1) begin
      errors++;
      $display("FAIL sc_success got cyc %0d load %h exp 0 1", cyc, load);
    end
    run_req(0, 1, 1, 32'h80, 32'h9, got, cyc, load);
    checks++;
    if (!got || cyc != 0 || load !== 32'h0) begin
      errors++;
      $display("FAIL sc_second got cyc %0d load %h exp 0 0", cyc, load);
    end
    run_req(1, 0, 0, 32'h80, 0, got, cyc, load);
    checks++;
    if (!got || load !== 32'h7) begin
      errors++;
      $display("FAIL sc_line_data got %h exp 7", load);
    end
    idle();
  endtask

  task automatic test_snoop();
    logic got; int cyc; logic [31:0] load;
    ev_q.delete();
    run_req(1, 0, 1, 32'h80, 0, got, cyc, load);
    @(negedge CLK);
    bus.dmemREN     = 1'b0;
    bus.datomic     = 1'b0;
    bus.snoop_valid = 1'b1;
    bus.snoop_addr  = 32'h82;
    run_req(0, 1, 1, 32'h80, 32'h99, got, cyc, load);
    bus.snoop_valid = 1'b0;
    checks++;
    if (!got || load !== 32'h0) begin
      errors++;
      $display("FAIL sc_after_snoop got %h exp 0", load);
    end
    run_req(1, 0, 0, 32'h80, 0, got, cyc, load);
    checks++;
    if (load !== 32'h7 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL snoop_no_write got line %h mem events %0d exp 7 0", load, ev_q.size());
    end
    idle();
  endtask

  task automatic test_flush();
    logic got; int cyc; logic [31:0] load;
    int n; logic saw_hit;
    ev_q.delete();
    run_req(1, 0, 0, 32'h40, 0, got, cyc, load);
    checks++;
    if (load !== 32'h1234 || ev_q.size() == 0 || ev_q[0] !== {1'b1, 32'h80, 32'h7}) begin
      errors++;
      $display("FAIL evict_sc_line got load %h exp 1234 after WB 80=7", load);
    end
    run_req(0, 1, 0, 32'h04, 32'hA1, got, cyc, load);
    run_req(0, 1, 0, 32'h14, 32'hB5, got, cyc, load);
    ev_q.delete();
    @(negedge CLK);
    bus.dmemWEN  = 1'b0;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h04;
    bus.halt     = 1'b1;
    #1;
    checks++;
    if (bus.dhit !== 1'b0) begin
      errors++;
      $display("FAIL halt_priority got dhit %b exp 0", bus.dhit);
    end
    n = 0;
    saw_hit = 1'b0;
    while (bus.flushed !== 1'b1 && n < 200) begin
      @(negedge CLK);
      #1;
      if (bus.dhit) saw_hit = 1'b1;
      n++;
    end
    checks++;
    if (bus.flushed !== 1'b1 || saw_hit) begin
      errors++;
      $display("FAIL flush_done got flushed %b dhit_seen %b exp 1 0", bus.flushed, saw_hit);
    end
    checks++;
    if (ev_q.size() != 2 || ev_q[0] !== {1'b1, 32'h04, 32'hA1} ||
        ev_q[1] !== {1'b1, 32'h14, 32'hB5}) begin
      errors++;
      $display("FAIL flush_writes got n=%0d exp 04=a1 then 14=b5", ev_q.size());
    end
    bus.halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      checks++;
      if ({bus.flushed, bus.dhit, bus.dREN, bus.dWEN} !== 4'b1000) begin
        errors++;
        $display("FAIL done_hold got %b exp 1000", {bus.flushed, bus.dhit, bus.dREN, bus.dWEN});
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_fill();
    logic got; int cyc; logic [31:0] load;
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checks++;
    if (bus.flushed !== 1'b0) begin
      errors++;
      $display("FAIL flushed_cleared got %b exp 0", bus.flushed);
    end
    mem[32'h200] = 32'h77;
    wait_cfg = 3;
    @(negedge CLK);
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h200;
    @(negedge CLK);
    #1;
    checks++;
    if (bus.dREN !== 1'b1 || bus.daddr !== 32'h200) begin
      errors++;
      $display("FAIL fetch_started got dREN %b daddr %h exp 1 00000200", bus.dREN, bus.daddr);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (bus.dREN !== 1'b0 || bus.daddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_fetch got dREN %b daddr %h exp 0 0", bus.dREN, bus.daddr);
    end
    bus.dmemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    wait_cfg = 0;
    run_req(1, 0, 0, 32'h200, 0, got, cyc, load);
    checks++;
    if (!got || cyc != 2 || load !== 32'h77) begin
      errors++;
      $display("FAIL refetch_after_reset got cyc %0d load %h exp 2 00000077", cyc, load);
    end
    idle();
  endtask

  initial begin
    bus.dmemREN     = 1'b0;
    bus.dmemWEN     = 1'b0;
    bus.datomic     = 1'b0;
    bus.dmemaddr    = '0;
    bus.dmemstore   = '0;
    bus.halt        = 1'b0;
    bus.snoop_valid = 1'b0;
    bus.snoop_addr  = '0;
    bus.dload       = '0;
    bus.dwait       = 1'b0;
    test_reset();
    test_cold_miss();
    test_dirty_evict();
    test_ll_sc();
    test_snoop();
    test_flush();
    test_reset_mid_fill();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL dren_dwen_overlap got %0d cycles exp 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
